// File: rtl/pin_controller_pkg.sv
// Shared definitions for the pin controller: bus field positions, register map,
// STATUS bit layout, mode/state encodings and small helper functions.
// Latency: n/a (definitions only). Backpressure: n/a.
package pin_controller_pkg;

    // Command bus fields
    localparam int BUS_ADDR_W = 19;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_POS_HI = 15;
    localparam int BUS_POS_LO = 8;
    localparam int BUS_OFF_HI = 7;
    localparam int BUS_OFF_LO = 0;

    // Register offsets
    localparam logic [7:0] REG_MODE       = 8'h00;
    localparam logic [7:0] REG_HIGH_TIME  = 8'h01;
    localparam logic [7:0] REG_LOW_TIME   = 8'h02;
    localparam logic [7:0] REG_SAMPLE_DIV = 8'h03;
    localparam logic [7:0] REG_CONST_VAL  = 8'h04;
    localparam logic [7:0] REG_STATUS     = 8'h05;

    // STATUS bit positions
    localparam int STAT_PIN_IN_BIT = 0;
    localparam int STAT_SVALID_BIT = 1;
    localparam int STAT_OVF_BIT    = 2;
    localparam int STAT_W          = 3;

    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        MODE_IDLE   = 3'd0,
        MODE_CONST  = 3'd1,
        MODE_SQUARE = 3'd2,
        MODE_RECORD = 3'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONST,
        ST_SQ_HIGH,
        ST_SQ_LOW,
        ST_RECORD
    } state_e;

    // Zero-length phases/dividers behave as one cycle.
    function automatic logic [31:0] at_least_one(input logic [31:0] t);
        return (t == 32'd0) ? 32'd1 : t;
    endfunction

    // Unused mode encodings (4-7) fall back to IDLE.
    function automatic state_e entry_state(input logic [2:0] m);
        case (m)
            MODE_CONST:  return ST_CONST;
            MODE_SQUARE: return ST_SQ_HIGH;
            MODE_RECORD: return ST_RECORD;
            default:     return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pin_controller_if.sv
// Command bus bundle: address/data/strobes towards the controller, readback out.
// Latency: n/a (wiring only). Backpressure: none, strobes are single-cycle fire-and-forget.
// Ports: master drives bus_addr/bus_data/bus_en/bus_wr/bus_rd, slave returns rd_data/rd_valid.
interface pin_controller_if;
    import pin_controller_pkg::*;

    logic [BUS_ADDR_W-1:0] bus_addr;
    logic [BUS_DATA_W-1:0] bus_data;
    logic                  bus_en;
    logic                  bus_wr;
    logic                  bus_rd;
    logic [BUS_DATA_W-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output bus_addr, bus_data, bus_en, bus_wr, bus_rd,
        input  rd_data, rd_valid
    );

    modport slave (
        input  bus_addr, bus_data, bus_en, bus_wr, bus_rd,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/pin_bus_decoder.sv
// Command bus decoder: controller select, per-register write enables, read mux and read register.
// Latency: writes are decoded combinationally; read data appears one cycle after the strobe.
// Backpressure: none; every selected strobe is serviced, write wins over a simultaneous read.
// Ports: bus (slave), register values/status in, write enables + write data + STATUS-read pulse out.
module pin_bus_decoder
    import pin_controller_pkg::*;
#(
    parameter logic [7:0] POSITION = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    pin_controller_if.slave       bus,
    input  logic [2:0]            mode_i,
    input  logic [31:0]           high_time_i,
    input  logic [31:0]           low_time_i,
    input  logic [31:0]           sample_div_i,
    input  logic                  const_val_i,
    input  logic [STAT_W-1:0]     status_i,
    output logic [BUS_DATA_W-1:0] wr_data_o,
    output logic                  we_mode_o,
    output logic                  we_high_o,
    output logic                  we_low_o,
    output logic                  we_div_o,
    output logic                  we_const_o,
    output logic                  status_rd_o
);

    logic        sel;
    logic        wr_hit;
    logic        rd_hit;
    logic [7:0]  off;
    logic [31:0] rd_mux;
    logic [31:0] rd_data_d, rd_data_q;
    logic        rd_valid_d, rd_valid_q;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^bus.bus_addr[BUS_ADDR_W-1:BUS_POS_HI+1];

    assign off    = bus.bus_addr[BUS_OFF_HI:BUS_OFF_LO];
    assign sel    = bus.bus_en && (bus.bus_addr[BUS_POS_HI:BUS_POS_LO] == POSITION);
    assign wr_hit = sel && bus.bus_wr;
    assign rd_hit = sel && bus.bus_rd && !bus.bus_wr;

    assign wr_data_o   = bus.bus_data;
    assign we_mode_o   = wr_hit && (off == REG_MODE);
    assign we_high_o   = wr_hit && (off == REG_HIGH_TIME);
    assign we_low_o    = wr_hit && (off == REG_LOW_TIME);
    assign we_div_o    = wr_hit && (off == REG_SAMPLE_DIV);
    assign we_const_o  = wr_hit && (off == REG_CONST_VAL);
    assign status_rd_o = rd_hit && (off == REG_STATUS);

    always_comb begin
        rd_mux = '0;
        case (off)
            REG_MODE:       rd_mux = {29'b0, mode_i};
            REG_HIGH_TIME:  rd_mux = high_time_i;
            REG_LOW_TIME:   rd_mux = low_time_i;
            REG_SAMPLE_DIV: rd_mux = sample_div_i;
            REG_CONST_VAL:  rd_mux = {31'b0, const_val_i};
            REG_STATUS:     rd_mux = {{(32-STAT_W){1'b0}}, status_i};
            default:        rd_mux = '0;
        endcase
    end

    // rd_data is forced to zero on cycles without a read response.
    assign rd_valid_d = rd_hit;
    assign rd_data_d  = rd_hit ? rd_mux : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: rtl/pin_controller.sv
// Pin controller: drives a constant level or square wave, or records the pin into 16-bit words.
// Latency: register writes act on the next edge; a finished sample word is presented the cycle after completion.
// Backpressure: sample_valid holds until sample_ready; a word completing while still held is dropped and flags OVERFLOW.
// Ports: clk/rst, command bus (slave), pin_in/pin_out/pin_oe, sample_data/sample_valid/sample_ready.
module pin_controller
    import pin_controller_pkg::*;
#(
    parameter logic [7:0] POSITION = 8'd0
) (
    input  logic                clk,
    input  logic                rst,
    pin_controller_if.slave     bus,
    input  logic                pin_in,
    output logic                pin_out,
    output logic                pin_oe,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready
);

    logic [31:0] wr_data;
    logic        we_mode, we_high, we_low, we_div, we_const, status_rd;

    logic [2:0]          mode_d, mode_q;
    logic [31:0]         high_d, high_q, low_d, low_q, div_d, div_q;
    logic                const_d, const_q;
    state_e              state_d, state_q;
    // A zero in cnt_q / div_lim_q means "not loaded yet": the next cycle reloads from the live register.
    logic [31:0]         cnt_d, cnt_q;
    logic [31:0]         div_cnt_d, div_cnt_q, div_lim_d, div_lim_q;
    logic [SAMPLE_W-1:0] shift_d, shift_q, sdata_d, sdata_q;
    logic [3:0]          shcnt_d, shcnt_q;
    logic                svalid_d, svalid_q, ovf_d, ovf_q;
    logic [STAT_W-1:0]   status;
    logic [31:0]         sq_eff, div_eff;
    logic [SAMPLE_W-1:0] word;

    always_comb begin
        status                  = '0;
        status[STAT_PIN_IN_BIT] = pin_in;
        status[STAT_SVALID_BIT] = svalid_q;
        status[STAT_OVF_BIT]    = ovf_q;
    end

    pin_bus_decoder #(.POSITION(POSITION)) u_dec (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mode_i       (mode_q),
        .high_time_i  (high_q),
        .low_time_i   (low_q),
        .sample_div_i (div_q),
        .const_val_i  (const_q),
        .status_i     (status),
        .wr_data_o    (wr_data),
        .we_mode_o    (we_mode),
        .we_high_o    (we_high),
        .we_low_o     (we_low),
        .we_div_o     (we_div),
        .we_const_o   (we_const),
        .status_rd_o  (status_rd)
    );

    assign mode_d  = we_mode  ? wr_data[2:0] : mode_q;
    assign high_d  = we_high  ? wr_data      : high_q;
    assign low_d   = we_low   ? wr_data      : low_q;
    assign div_d   = we_div   ? wr_data      : div_q;
    assign const_d = we_const ? wr_data[0]   : const_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_cnt_d = div_cnt_q;
        div_lim_d = div_lim_q;
        shift_d   = shift_q;
        shcnt_d   = shcnt_q;
        sdata_d   = sdata_q;
        svalid_d  = svalid_q;
        ovf_d     = ovf_q;
        sq_eff    = '0;
        div_eff   = '0;
        word      = '0;
        pin_out   = 1'b0;
        pin_oe    = 1'b0;

        if (svalid_q && sample_ready) svalid_d = 1'b0;
        if (status_rd)                ovf_d    = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_CONST: begin
                pin_oe  = 1'b1;
                pin_out = const_q;
            end
            ST_SQ_HIGH, ST_SQ_LOW: begin
                pin_oe  = 1'b1;
                pin_out = (state_q == ST_SQ_HIGH);
                if (cnt_q != 32'd0)           sq_eff = cnt_q;
                else if (state_q == ST_SQ_HIGH) sq_eff = at_least_one(high_q);
                else                          sq_eff = at_least_one(low_q);
                if (sq_eff == 32'd1) begin
                    state_d = (state_q == ST_SQ_HIGH) ? ST_SQ_LOW : ST_SQ_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sq_eff - 32'd1;
                end
            end
            ST_RECORD: begin
                div_eff = (div_lim_q != 32'd0) ? div_lim_q : at_least_one(div_q);
                if (div_cnt_q == div_eff - 32'd1) begin
                    div_cnt_d = '0;
                    div_lim_d = '0;
                    // Shift in at the top so the oldest sample ends up in bit 0.
                    word      = {pin_in, shift_q[SAMPLE_W-1:1]};
                    shift_d   = word;
                    shcnt_d   = shcnt_q + 4'd1;
                    if (shcnt_q == 4'd15) begin
                        if (!svalid_q || sample_ready) begin
                            sdata_d  = word;
                            svalid_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                    div_lim_d = div_eff;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A MODE write always restarts, even when rewriting the current mode.
        if (we_mode) begin
            state_d   = entry_state(wr_data[2:0]);
            cnt_d     = '0;
            div_cnt_d = '0;
            div_lim_d = '0;
            shift_d   = '0;
            shcnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= '0;
            high_q    <= '0;
            low_q     <= '0;
            div_q     <= '0;
            const_q   <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_cnt_q <= '0;
            div_lim_q <= '0;
            shift_q   <= '0;
            shcnt_q   <= '0;
            sdata_q   <= '0;
            svalid_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            high_q    <= high_d;
            low_q     <= low_d;
            div_q     <= div_d;
            const_q   <= const_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_cnt_q <= div_cnt_d;
            div_lim_q <= div_lim_d;
            shift_q   <= shift_d;
            shcnt_q   <= shcnt_d;
            sdata_q   <= sdata_d;
            svalid_q  <= svalid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign sample_data  = sdata_q;
    assign sample_valid = svalid_q;

endmodule

// File: tb/tb_pin_controller.sv
// Bench for pin_controller (POSITION=3): directed bus sequences with queued expected
// read/sample responses checked by independent monitors, plus direct pin checks.
// Latency: n/a. Backpressure: sample_ready driven by the stimulus.
module tb_pin_controller;
    import pin_controller_pkg::*;

    localparam logic [7:0] POS = 8'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pin_in;
    logic        pin_out;
    logic        pin_oe;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] rd_q[$];
    logic [15:0] smp_q[$];
    int          hs_cyc[$];
    logic [31:0] rd_exp;
    logic [15:0] smp_exp;

    pin_controller_if bus ();

    pin_controller #(.POSITION(POS)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .pin_in       (pin_in),
        .pin_out      (pin_out),
        .pin_oe       (pin_oe),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pins();
        return {30'b0, pin_oe, pin_out};
    endfunction

    function automatic logic [18:0] A(input logic [7:0] pos, input logic [7:0] off);
        return {3'b000, pos, off};
    endfunction

    task automatic bus_cmd(input logic [18:0] a, input logic [31:0] d, input logic wr, input logic rd);
        @(posedge clk); #1;
        bus.bus_addr = a;
        bus.bus_data = d;
        bus.bus_en   = 1'b1;
        bus.bus_wr   = wr;
        bus.bus_rd   = rd;
        @(posedge clk); #1;
        bus.bus_en = 1'b0;
        bus.bus_wr = 1'b0;
        bus.bus_rd = 1'b0;
    endtask

    task automatic bus_write(input logic [18:0] a, input logic [31:0] d);
        bus_cmd(a, d, 1'b1, 1'b0);
    endtask

    // The expected response is queued after the strobe edge, before the monitor samples it.
    task automatic bus_read(input logic [18:0] a, input logic resp, input logic [31:0] exp);
        bus_cmd(a, 32'h0, 1'b0, 1'b1);
        if (resp) rd_q.push_back(exp);
    endtask

    // Read response monitor
    always @(negedge clk) begin
        if (!rst && bus.rd_valid) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: actual rd_valid=1 data=0x%0h required no response", bus.rd_data);
            end else begin
                rd_exp = rd_q.pop_front();
                check("rd_data", bus.rd_data, rd_exp);
            end
        end
    end

    // Sample stream monitor: a transfer happens on the edge after valid&ready is seen here.
    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            hs_cyc.push_back(cyc);
            if (smp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL smp_unexpected: actual data=0x%0h required no transfer", sample_data);
            end else begin
                smp_exp = smp_q.pop_front();
                check("sample_data", 32'(sample_data), 32'(smp_exp));
            end
        end
    end

    initial begin
        rst          = 1'b1;
        pin_in       = 1'b0;
        sample_ready = 1'b1;
        bus.bus_addr = '0;
        bus.bus_data = '0;
        bus.bus_en   = 1'b0;
        bus.bus_wr   = 1'b0;
        bus.bus_rd   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pins", pins(), 32'h0);
        check("rst_svalid", 32'(sample_valid), 32'h0);
        check("rst_sdata", 32'(sample_data), 32'h0);
        check("rst_rdvalid", 32'(bus.rd_valid), 32'h0);
        check("rst_rddata", bus.rd_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Square wave 2 high / 3 low
        bus_write(A(POS, REG_HIGH_TIME), 32'd2);
        bus_write(A(POS, REG_LOW_TIME), 32'd3);
        bus_write(A(POS, REG_MODE), 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("square_2_3", pins(), ((i % 5) < 2) ? 32'd3 : 32'd2);
        end
        bus_read(A(POS, REG_HIGH_TIME), 1'b1, 32'd2);
        bus_read(A(POS, REG_LOW_TIME), 1'b1, 32'd3);
        bus_read(A(POS, REG_MODE), 1'b1, 32'd2);

        // Zero phase times: toggle every cycle
        bus_write(A(POS, REG_HIGH_TIME), 32'd0);
        bus_write(A(POS, REG_LOW_TIME), 32'd0);
        bus_write(A(POS, REG_MODE), 32'd2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("square_0_0", pins(), ((i % 2) == 0) ? 32'd3 : 32'd2);
        end

        // Wrong position, CONST, unmapped modes, write-wins
        bus_write(A(POS, REG_MODE), 32'd0);
        @(negedge clk);
        check("idle_pins", pins(), 32'h0);
        bus_write(A(8'd4, REG_MODE), 32'd1);
        @(negedge clk);
        check("wrongpos_pins", pins(), 32'h0);
        bus_read(A(8'd4, REG_MODE), 1'b0, 32'h0);
        bus_read(A(POS, REG_MODE), 1'b1, 32'd0);
        bus_write(A(POS, REG_CONST_VAL), 32'd1);
        bus_write(A(POS, REG_MODE), 32'd1);
        @(negedge clk);
        check("const1_pins", pins(), 32'd3);
        bus_write(A(POS, REG_CONST_VAL), 32'd0);
        @(negedge clk);
        check("const0_pins", pins(), 32'd2);
        bus_write(A(POS, REG_MODE), 32'd5);
        @(negedge clk);
        check("mode5_pins", pins(), 32'h0);
        bus_read(A(POS, REG_MODE), 1'b1, 32'd5);
        bus_cmd(A(POS, REG_CONST_VAL), 32'd1, 1'b1, 1'b1);
        bus_read(A(POS, REG_CONST_VAL), 1'b1, 32'd1);
        bus_write({3'b111, POS, REG_SAMPLE_DIV}, 32'd7);
        bus_read(A(POS, REG_SAMPLE_DIV), 1'b1, 32'd7);
        bus_read(A(POS, 8'h07), 1'b1, 32'd0);
        bus_write(A(POS, REG_MODE), 32'd1);
        @(negedge clk);
        check("const_again_pins", pins(), 32'd3);
        bus_write(A(POS, REG_MODE), 32'd0);
        @(negedge clk);
        check("back_idle_pins", pins(), 32'h0);

        // Record with divider 1, alternating pin starting at 0
        bus_write(A(POS, REG_SAMPLE_DIV), 32'd1);
        pin_in = 1'b0;
        hs_cyc.delete();
        for (int i = 0; i < 3; i++) smp_q.push_back(16'hAAAA);
        bus_write(A(POS, REG_MODE), 32'd3);
        for (int i = 0; i < 52; i++) begin
            @(posedge clk); #1;
            pin_in = ~pin_in;
        end
        pin_in = 1'b0;
        bus_write(A(POS, REG_MODE), 32'd0);
        check("record_words", hs_cyc.size(), 32'd3);
        if (hs_cyc.size() == 3) begin
            check("record_gap1", hs_cyc[1] - hs_cyc[0], 32'd16);
            check("record_gap2", hs_cyc[2] - hs_cyc[1], 32'd16);
        end

        // Overflow: first word all ones is held, second word (zeros) dropped
        sample_ready = 1'b0;
        pin_in       = 1'b1;
        bus_write(A(POS, REG_MODE), 32'd3);
        repeat (16) @(posedge clk);
        #1 pin_in = 1'b0;
        repeat (24) @(posedge clk);
        bus_write(A(POS, REG_MODE), 32'd0);
        @(negedge clk);
        check("ovf_held_valid", 32'(sample_valid), 32'd1);
        bus_read(A(POS, REG_STATUS), 1'b1, 32'h6);
        bus_read(A(POS, REG_STATUS), 1'b1, 32'h2);
        smp_q.push_back(16'hFFFF);
        @(posedge clk); #1;
        sample_ready = 1'b1;
        repeat (2) @(posedge clk);
        bus_read(A(POS, REG_STATUS), 1'b1, 32'h0);

        // Asynchronous reset in the middle of SQ_HIGH
        bus_write(A(POS, REG_HIGH_TIME), 32'd4);
        bus_write(A(POS, REG_MODE), 32'd2);
        @(negedge clk);
        check("pre_rst_pins", pins(), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pins", pins(), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int off = 0; off < 6; off++) bus_read(A(POS, 8'(off)), 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", pins(), 32'h0);
        end
        check("post_rst_svalid", 32'(sample_valid), 32'h0);

        repeat (3) @(posedge clk);
        check("rd_queue_empty", rd_q.size(), 32'd0);
        check("smp_queue_empty", smp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
